stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 The block SHALL have parameter SP_TOP, default 8'd255, meaning the empty-stack SP value and the pop-underflow boundary.
REQ-002 The block SHALL have parameter SP_REG, default 2'd3, meaning the register-file index holding SP.
REQ-003 The block SHALL have one clock, port clk (input, 1), with all state changing on its rising edge.
REQ-004 The block SHALL have reset port rst (input, 1), asynchronous and active-high.
REQ-005 The block SHALL have the following op-handshake ports:
- op_valid (input, 1): stack-op request.
- op_push (input, 1): 1 = PUSH, 0 = POP.
- push_data (input, 8): byte to push.
- op_ready (output, 1): request can be accepted.
REQ-006 The block SHALL have sp_in (input, 8): current SP as read from the register file.
REQ-007 The block SHALL have the following pipeline-writeback ports:
- wb_en (input, 1): writeback request.
- wb_addr (input, 2): writeback register index.
- wb_data (input, 8): writeback data.
REQ-008 The block SHALL have the following register-file write-port outputs:
- rf_wr_en (output, 1).
- rf_waddr (output, 2).
- rf_wdata (output, 8).
REQ-009 The block SHALL have the following data-memory ports:
- mem_addr (output, 8).
- mem_we (output, 1).
- mem_re (output, 1).
- mem_wdata (output, 8).
- mem_rdata (input, 8): valid the cycle after mem_re.
REQ-010 The block SHALL have the following status outputs:
- done (output, 1): 1-cycle completion pulse.
- pop_data (output, 8): last popped byte.
- err_ovf (output, 1): push-overflow pulse.
- err_unf (output, 1): pop-underflow pulse.
- err_conflict (output, 1): SP-write conflict pulse.

Function
REQ-011 The block SHALL implement states IDLE, PUSH_WR, POP_RD, POP_CAP and SP_WR.
REQ-012 op_ready SHALL be 1 exactly when the state is IDLE.
REQ-013 A request SHALL be accepted when op_valid & op_ready, at which point sp_in is latched into sp_q and push_data is latched.
REQ-014 When a PUSH is accepted with sp_in==0, it SHALL be rejected: no memory access, state stays IDLE, err_ovf=1 in the next cycle, no done.
REQ-015 When a POP is accepted with sp_in==SP_TOP, it SHALL be rejected: no memory access, state stays IDLE, err_unf=1 in the next cycle, no done.
REQ-016 For an accepted, valid PUSH the block SHALL go IDLE->PUSH_WR, and in PUSH_WR drive mem_we=1, mem_addr=sp_q, mem_wdata=latched push_data; then go to SP_WR with new SP = sp_q-1.
REQ-017 For an accepted, valid POP the block SHALL go IDLE->POP_RD, and in POP_RD drive mem_re=1, mem_addr=sp_q+1.
REQ-018 From POP_RD the block SHALL go to POP_CAP, where it registers mem_rdata into pop_data, then go to SP_WR with new SP = sp_q+1.
REQ-019 All SP arithmetic SHALL be 8-bit modulo; the overflow and underflow checks guarantee no wrap occurs for accepted ops.
REQ-020 The write port SHALL be arbitrated with the pipeline having priority: when wb_en=1, rf_wr_en=1, rf_waddr=wb_addr, rf_wdata=wb_data, in any state.
REQ-021 In SP_WR with wb_en=0, the block SHALL drive rf_wr_en=1, rf_waddr=SP_REG, rf_wdata=new SP, pulse done=1, and return to IDLE.
REQ-022 In SP_WR with wb_en=1, the block SHALL hold SP_WR with no done, and retry every cycle; the stall is unbounded.
REQ-023 When wb_en=1 and wb_addr==SP_REG in any non-IDLE state, err_conflict SHALL pulse for 1 cycle per occurrence, and the sequencer's SP write SHALL still occur later (the sequencer is the last writer).
REQ-024 Latency with no stall SHALL be: PUSH accepted at T -> mem_we at T+1 -> SP write and done at T+2 -> op_ready at T+3.
REQ-025 Latency with no stall SHALL be: POP accepted at T -> mem_re at T+1 -> capture at T+2 -> SP write and done at T+3 -> op_ready at T+4.
REQ-026 pop_data SHALL be held from POP_CAP+1 until the next POP capture.
REQ-027 mem_we and mem_re SHALL never both be 1.
REQ-028 mem_we and mem_re SHALL each be 1 only in their named states.
REQ-029 op_valid or op_push changing while not ready SHALL be ignored.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, pop_data=0, and done, err_ovf, err_unf, err_conflict, mem_we and mem_re all 0, with sp_q=0.
REQ-031 When rst=1 and wb_en=0, rf_wr_en SHALL be 0.
REQ-032 Reset mid-operation SHALL abandon the op with no SP write; op_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 mem_addr and mem_wdata SHALL be 0 while rst=1.

Verification
REQ-034 PUSH sp_in=255, push_data=0xA5 -> T+1: mem_we=1, addr=255, wdata=0xA5; T+2: rf_wr_en=1, waddr=3, wdata=254, done=1.
REQ-035 POP sp_in=254, mem_rdata=0xA5 at T+2 -> T+1: mem_re=1, addr=255; T+3: rf write R3=255, done=1, pop_data=0xA5.
REQ-036 PUSH sp_in=0 -> err_ovf=1 at T+1, no mem_we, no rf write, op_ready=1 at T+1; POP sp_in=255 -> err_unf=1 at T+1, likewise.
REQ-037 PUSH sp_in=10 with wb_en=1, wb_addr=1 held 3 cycles from T+2 -> pipeline writes pass through, done delayed to T+5 with R3=9.
REQ-038 wb_en=1, wb_addr=3 during PUSH_WR -> err_conflict=1 that cycle; SP_WR still writes sp_q-1.
REQ-039 rst pulsed during POP_CAP -> no done, no rf write of SP, op_ready=1 the cycle after release; a following POP completes normally.

Source files
------------

// File: rtl/stack_sequencer.sv
// Stack sequencer: turns PUSH/POP requests into a data-memory access followed by an SP
// writeback. The SP writeback shares the register-file write port, and pipeline writes win.
module stack_sequencer #(
    parameter logic [7:0] SP_TOP = 8'd255,
    parameter logic [1:0] SP_REG = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic       op_push,
    input  logic [7:0] push_data,
    output logic       op_ready,
    input  logic [7:0] sp_in,
    input  logic       wb_en,
    input  logic [1:0] wb_addr,
    input  logic [7:0] wb_data,
    output logic       rf_wr_en,
    output logic [1:0] rf_waddr,
    output logic [7:0] rf_wdata,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       done,
    output logic [7:0] pop_data,
    output logic       err_ovf,
    output logic       err_unf,
    output logic       err_conflict
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PUSH_WR = 3'd1;
    localparam logic [2:0] POP_RD  = 3'd2;
    localparam logic [2:0] POP_CAP = 3'd3;
    localparam logic [2:0] SP_WR   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] data_q, data_d;
    logic       push_q, push_d;
    logic [7:0] pop_data_q, pop_data_d;
    logic       err_ovf_q, err_ovf_d;
    logic       err_unf_q, err_unf_d;
    logic [7:0] new_sp;

    assign new_sp = push_q ? (sp_q - 8'd1) : (sp_q + 8'd1);

    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        data_d     = data_q;
        push_d     = push_q;
        pop_data_d = pop_data_q;
        err_ovf_d  = 1'b0;
        err_unf_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    sp_d   = sp_in;
                    data_d = push_data;
                    push_d = op_push;
                    // Rejected ops stay in IDLE and only raise the error pulse next cycle.
                    if (op_push) begin
                        if (sp_in == 8'd0) err_ovf_d = 1'b1;
                        else               state_d   = PUSH_WR;
                    end else begin
                        if (sp_in == SP_TOP) err_unf_d = 1'b1;
                        else                 state_d   = POP_RD;
                    end
                end
            end
            PUSH_WR: state_d = SP_WR;
            POP_RD:  state_d = POP_CAP;
            POP_CAP: begin
                pop_data_d = mem_rdata;
                state_d    = SP_WR;
            end
            SP_WR:   if (!wb_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sp_q       <= 8'd0;
            data_q     <= 8'd0;
            push_q     <= 1'b0;
            pop_data_q <= 8'd0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            data_q     <= data_d;
            push_q     <= push_d;
            pop_data_q <= pop_data_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
        end
    end

    always_comb begin
        op_ready     = (state_q == IDLE);
        mem_we       = (state_q == PUSH_WR);
        mem_re       = (state_q == POP_RD);
        mem_addr     = 8'd0;
        mem_wdata    = 8'd0;
        if (state_q == PUSH_WR) begin
            mem_addr  = sp_q;
            mem_wdata = data_q;
        end else if (state_q == POP_RD) begin
            mem_addr  = sp_q + 8'd1;
        end
        rf_wr_en     = 1'b0;
        rf_waddr     = 2'd0;
        rf_wdata     = 8'd0;
        done         = 1'b0;
        // The pipeline owns the write port whenever it asks; the SP write just retries.
        if (wb_en) begin
            rf_wr_en = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
        end else if (state_q == SP_WR) begin
            rf_wr_en = 1'b1;
            rf_waddr = SP_REG;
            rf_wdata = new_sp;
            done     = 1'b1;
        end
        err_conflict = wb_en && (wb_addr == SP_REG) && (state_q != IDLE);
        err_ovf      = err_ovf_q;
        err_unf      = err_unf_q;
        pop_data     = pop_data_q;
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed stack ops with literal checks, plus an op-level model
// of pending actions that is compared against every output on each falling edge.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_push = 1'b0;
    logic [7:0] push_data = 8'd0;
    logic       op_ready;
    logic [7:0] sp_in = 8'd0;
    logic       wb_en = 1'b0;
    logic [1:0] wb_addr = 2'd0;
    logic [7:0] wb_data = 8'd0;
    logic       rf_wr_en;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'd0;
    logic       done;
    logic [7:0] pop_data;
    logic       err_ovf;
    logic       err_unf;
    logic       err_conflict;

    int n_tests = 0;
    int n_fail  = 0;

    stack_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_push(op_push), .push_data(push_data),
        .op_ready(op_ready), .sp_in(sp_in), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .rf_wr_en(rf_wr_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .done(done), .pop_data(pop_data), .err_ovf(err_ovf),
        .err_unf(err_unf), .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    // Data memory with one-cycle read latency.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, got, got, exp, exp, $time);
        end
    endtask

    // Model: each accepted op expands into a list of remaining actions.
    localparam int A_MEMW = 0, A_MEMR = 1, A_CAP = 2, A_SPW = 3;
    int m_plan[$];
    int m_sp = 0, m_data = 0, m_pop = 0;
    bit m_push = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_plan.delete();
            m_pop = 0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            m_ovf = 1'b0; m_unf = 1'b0;
            if (m_plan.size() == 0) begin
                if (op_valid) begin
                    m_sp = int'(sp_in); m_data = int'(push_data); m_push = op_push;
                    if (op_push && m_sp == 0)         m_ovf = 1'b1;
                    else if (!op_push && m_sp == 255) m_unf = 1'b1;
                    else if (op_push)                 m_plan = '{A_MEMW, A_SPW};
                    else                              m_plan = '{A_MEMR, A_CAP, A_SPW};
                end
            end else begin
                if (m_plan[0] == A_CAP) m_pop = int'(mem_rdata);
                if (!(m_plan[0] == A_SPW && wb_en)) void'(m_plan.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        int act, e_addr, e_wdata, e_rfa, e_rfd, nsp;
        bit e_busy, e_rfen, e_done;
        if (rst) begin
            chk("rst_ready", op_ready, 1);
            chk("rst_done", done, 0);
            chk("rst_memwe", mem_we, 0);
            chk("rst_memre", mem_re, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_pop", pop_data, 0);
            chk("rst_errs", {err_ovf, err_unf, err_conflict}, 0);
            chk("rst_rfen", rf_wr_en, wb_en);
        end else begin
            e_busy = m_plan.size() != 0;
            act = e_busy ? m_plan[0] : -1;
            e_addr = (act == A_MEMW) ? m_sp : (act == A_MEMR) ? ((m_sp + 1) & 255) : 0;
            e_wdata = (act == A_MEMW) ? m_data : 0;
            nsp = m_push ? ((m_sp - 1) & 255) : ((m_sp + 1) & 255);
            e_done = (act == A_SPW) && !wb_en;
            e_rfen = wb_en || e_done;
            e_rfa = wb_en ? int'(wb_addr) : 3;
            e_rfd = wb_en ? int'(wb_data) : nsp;
            chk("m_ready", op_ready, !e_busy);
            chk("m_memwe", mem_we, act == A_MEMW);
            chk("m_memre", mem_re, act == A_MEMR);
            chk("m_addr", mem_addr, e_addr);
            chk("m_wdata", mem_wdata, e_wdata);
            chk("m_rfen", rf_wr_en, e_rfen);
            if (e_rfen) begin
                chk("m_rfaddr", rf_waddr, e_rfa);
                chk("m_rfdata", rf_wdata, e_rfd);
            end
            chk("m_done", done, e_done);
            chk("m_pop", pop_data, m_pop);
            chk("m_ovf", err_ovf, m_ovf);
            chk("m_unf", err_unf, m_unf);
            chk("m_conflict", err_conflict, e_busy && wb_en && wb_addr == 2'd3);
        end
        chk("m_we_re_excl", mem_we && mem_re, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit push, input int sp, input int data);
        op_valid = 1'b1; op_push = push; sp_in = 8'(sp); push_data = 8'(data);
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("reset_pop_data", pop_data, 0);
        rst = 1'b0;
        step();

        // PUSH 0xA5 onto an empty stack.
        issue(1'b1, 255, 8'hA5);
        chk("push_memwe", mem_we, 1);
        chk("push_addr", mem_addr, 255);
        chk("push_wdata", mem_wdata, 8'hA5);
        step();
        chk("push_rf", {rf_wr_en, rf_waddr, rf_wdata}, {1'b1, 2'd3, 8'd254});
        chk("push_done", done, 1);
        step();
        chk("push_ready_t3", op_ready, 1);

        // POP it back.
        issue(1'b0, 254, 0);
        chk("pop_memre", mem_re, 1);
        chk("pop_addr", mem_addr, 255);
        step();
        chk("pop_rdata_t2", mem_rdata, 8'hA5);
        step();
        chk("pop_rf", {rf_wr_en, rf_waddr, rf_wdata}, {1'b1, 2'd3, 8'd255});
        chk("pop_done", done, 1);
        chk("pop_data", pop_data, 8'hA5);
        step();
        chk("pop_ready_t4", op_ready, 1);

        // Overflow and underflow rejects.
        issue(1'b1, 0, 8'h11);
        chk("ovf_pulse", err_ovf, 1);
        chk("ovf_nomem", mem_we, 0);
        chk("ovf_norf", rf_wr_en, 0);
        chk("ovf_ready", op_ready, 1);
        step();
        chk("ovf_one_cycle", err_ovf, 0);
        issue(1'b0, 255, 0);
        chk("unf_pulse", err_unf, 1);
        chk("unf_nomem", mem_re, 0);
        chk("unf_ready", op_ready, 1);
        step();

        // PUSH stalled three cycles by pipeline writes; busy-time requests are ignored.
        issue(1'b1, 10, 8'h3C);
        op_valid = 1'b1; op_push = 1'b0; sp_in = 8'd99;
        step();
        op_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pass_addr", rf_waddr, 1);
            chk("stall_no_done", done, 0);
            step();
        end
        wb_en = 1'b0;
        #1;
        chk("stall_done_t5", done, 1);
        chk("stall_sp", rf_wdata, 9);
        step();

        // Pipeline writes SP during PUSH_WR: conflict flagged, SP still written after.
        issue(1'b1, 20, 8'h5A);
        wb_en = 1'b1; wb_addr = 2'd3; wb_data = 8'h11;
        #1;
        chk("conflict_pulse", err_conflict, 1);
        chk("conflict_pass", rf_wdata, 8'h11);
        step();
        wb_en = 1'b0;
        #1;
        chk("conflict_sp_write", {done, rf_wdata}, {1'b1, 8'd19});
        step();

        // Reset during POP_CAP abandons the op; a fresh POP then completes.
        issue(1'b0, 19, 0);
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", op_ready, 1);
        chk("rst_mid_done", done, 0);
        step();
        rst = 1'b0;
        step();
        chk("rst_release_ready", op_ready, 1);
        chk("rst_release_norf", rf_wr_en, 0);
        issue(1'b0, 19, 0);
        step();
        step();
        chk("pop2_data", pop_data, 8'h5A);
        chk("pop2_sp", {done, rf_wdata}, {1'b1, 8'd20});
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
